// File: rtl/soc_bus_fabric.sv
// soc_bus_fabric: shared-bus interconnect with round-robin arbitration, registered
// request/response paths, decode-error and timeout responses; one transaction in flight.
module soc_bus_fabric #(
    parameter int NUM_MASTERS    = 2,
    parameter int NUM_SLAVES     = 3,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SEL_WIDTH      = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_MASTERS-1:0]           m_req_valid,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
    input  logic [NUM_MASTERS-1:0]           m_we,
    output logic [NUM_MASTERS-1:0]           m_data_valid,
    output logic [DATA_WIDTH-1:0]            m_rdata,
    output logic                             m_err,
    output logic [NUM_SLAVES-1:0]            s_req_valid,
    output logic [ADDR_WIDTH-1:0]            s_addr,
    output logic [DATA_WIDTH-1:0]            s_wdata,
    output logic                             s_we,
    input  logic [NUM_SLAVES-1:0]            s_data_valid,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
    output logic                             busy
);

    localparam int GW    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [GW-1:0]          last_grant_q, last_grant_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_SLAVES-1:0]  s_req_valid_q, s_req_valid_d;
    logic [ADDR_WIDTH-1:0]  s_addr_q, s_addr_d;
    logic [DATA_WIDTH-1:0]  s_wdata_q, s_wdata_d;
    logic                   s_we_q, s_we_d;
    logic [NUM_MASTERS-1:0] m_data_valid_q, m_data_valid_d;
    logic [DATA_WIDTH-1:0]  m_rdata_q, m_rdata_d;
    logic                   m_err_q, m_err_d;

    logic                   arb_found;
    logic [GW-1:0]          arb_idx;
    logic [ADDR_WIDTH-1:0]  req_addr;
    logic [DATA_WIDTH-1:0]  req_wdata;
    logic                   req_we;
    logic [SEL_WIDTH-1:0]   req_sel;
    logic                   dec_err;
    logic [DATA_WIDTH-1:0]  slv_rdata;
    logic                   slv_done;

    // Round-robin: the first requester found scanning upward from last_grant+1 wins.
    always_comb begin
        int cand;
        arb_found = 1'b0;
        arb_idx   = last_grant_q;
        cand      = 0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = int'(last_grant_q) + k;
            if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
            if (!arb_found && m_req_valid[GW'(cand)]) begin
                arb_found = 1'b1;
                arb_idx   = GW'(cand);
            end
        end
    end

    assign req_addr  = m_addr[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign req_wdata = m_wdata[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign req_we    = m_we[arb_idx];
    assign req_sel   = req_addr[ADDR_WIDTH-1 -: SEL_WIDTH];
    assign dec_err   = (32'(req_sel) >= 32'(NUM_SLAVES));

    // The registered one-hot request doubles as the read-data mux select.
    always_comb begin
        slv_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (s_req_valid_q[i]) slv_rdata = s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign slv_done = |(s_data_valid & s_req_valid_q);

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        cnt_d          = cnt_q;
        s_req_valid_d  = s_req_valid_q;
        s_addr_d       = s_addr_q;
        s_wdata_d      = s_wdata_q;
        s_we_d         = s_we_q;
        m_data_valid_d = '0;
        m_rdata_d      = m_rdata_q;
        m_err_d        = m_err_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    last_grant_d = arb_idx;
                    s_addr_d     = req_addr;
                    s_wdata_d    = req_wdata;
                    s_we_d       = req_we;
                    cnt_d        = '0;
                    if (dec_err) begin
                        state_d        = ST_RESP;
                        m_data_valid_d = NUM_MASTERS'(1) << arb_idx;
                        m_rdata_d      = '0;
                        m_err_d        = 1'b1;
                    end else begin
                        state_d       = ST_WAIT;
                        s_req_valid_d = NUM_SLAVES'(1) << req_sel;
                    end
                end
            end
            ST_WAIT: begin
                // Completion is tested first so it wins over a same-cycle timeout.
                if (slv_done) begin
                    state_d        = ST_RESP;
                    s_req_valid_d  = '0;
                    m_data_valid_d = NUM_MASTERS'(1) << last_grant_q;
                    m_rdata_d      = s_we_q ? '0 : slv_rdata;
                    m_err_d        = 1'b0;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    state_d        = ST_RESP;
                    s_req_valid_d  = '0;
                    m_data_valid_d = NUM_MASTERS'(1) << last_grant_q;
                    m_rdata_d      = '0;
                    m_err_d        = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d   = ST_IDLE;
                cnt_d     = '0;
                m_rdata_d = '0;
                m_err_d   = 1'b0;
            end
            default: begin
                state_d       = ST_IDLE;
                s_req_valid_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            last_grant_q   <= GW'(NUM_MASTERS - 1);
            cnt_q          <= '0;
            s_req_valid_q  <= '0;
            s_addr_q       <= '0;
            s_wdata_q      <= '0;
            s_we_q         <= 1'b0;
            m_data_valid_q <= '0;
            m_rdata_q      <= '0;
            m_err_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            cnt_q          <= cnt_d;
            s_req_valid_q  <= s_req_valid_d;
            s_addr_q       <= s_addr_d;
            s_wdata_q      <= s_wdata_d;
            s_we_q         <= s_we_d;
            m_data_valid_q <= m_data_valid_d;
            m_rdata_q      <= m_rdata_d;
            m_err_q        <= m_err_d;
        end
    end

    assign m_data_valid = m_data_valid_q;
    assign m_rdata      = m_rdata_q;
    assign m_err        = m_err_q;
    assign s_req_valid  = s_req_valid_q;
    assign s_addr       = s_addr_q;
    assign s_wdata      = s_wdata_q;
    assign s_we         = s_we_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Bench for soc_bus_fabric: directed and randomized transactions checked against
// a transaction-level model of arbitration, decode, latency and response data.
module tb_soc_bus_fabric;

    localparam int NM = 2;
    localparam int NS = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NM-1:0]     m_req_valid;
    logic [NM*AW-1:0]  m_addr;
    logic [NM*DW-1:0]  m_wdata;
    logic [NM-1:0]     m_we;
    logic [NM-1:0]     m_data_valid;
    logic [DW-1:0]     m_rdata;
    logic              m_err;
    logic [NS-1:0]     s_req_valid;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_wdata;
    logic              s_we;
    logic [NS-1:0]     s_data_valid;
    logic [NS*DW-1:0]  s_rdata;
    logic              busy;

    soc_bus_fabric #(
        .NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .SEL_WIDTH(2), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .m_req_valid(m_req_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we),
        .m_data_valid(m_data_valid), .m_rdata(m_rdata), .m_err(m_err),
        .s_req_valid(s_req_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we),
        .s_data_valid(s_data_valid), .s_rdata(s_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Master-side request intentions and the model's arbitration memory.
    logic [NM-1:0] rq_v;
    logic [31:0]   rq_addr [NM];
    logic [31:0]   rq_wdata[NM];
    logic          rq_we   [NM];
    int            model_last = NM - 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_masters();
        m_req_valid = rq_v;
        for (int i = 0; i < NM; i++) begin
            m_addr[i*AW +: AW]  = rq_addr[i];
            m_wdata[i*DW +: DW] = rq_wdata[i];
            m_we[i]             = rq_we[i];
        end
    endtask

    function automatic int rr_pick(input logic [NM-1:0] mask);
        for (int k = 1; k <= NM; k++) begin
            int c;
            c = (model_last + k) % NM;
            if (mask[c]) return c;
        end
        return -1;
    endfunction

    // Runs one transaction starting in the current (IDLE) cycle. delay = WAIT cycle index
    // in which the target slave strobes (negative = never); ends in the IDLE cycle after RESP.
    task automatic run_txn(input int delay, input bit stray, input bit fixed, input logic [31:0] rdv);
        int          w;
        int          sel;
        int          si;
        int          c;
        bit          done;
        logic [NM-1:0] exp_mdv;
        logic [NS-1:0] exp_srv;
        logic [31:0] exp_rd;
        logic        exp_err;
        w          = rr_pick(rq_v);
        model_last = w;
        sel        = int'(rq_addr[w][31:30]);
        si         = (sel == 0) ? 1 : 0;
        exp_mdv    = '0;
        exp_mdv[w] = 1'b1;
        exp_rd     = '0;
        exp_err    = 1'b0;
        drive_masters();
        s_data_valid = '0;
        tick();
        check("busy_after_grant", busy, 1'b1);
        if (sel >= NS) begin
            check("decerr_srv", s_req_valid, '0);
            check("decerr_mdv", m_data_valid, exp_mdv);
            check("decerr_err", m_err, 1'b1);
            check("decerr_rdata", m_rdata, '0);
        end else begin
            exp_srv      = '0;
            exp_srv[sel] = 1'b1;
            c    = 0;
            done = 1'b0;
            while (!done) begin
                check("wait_srv", s_req_valid, exp_srv);
                check("wait_saddr", s_addr, rq_addr[w]);
                check("wait_swdata", s_wdata, rq_wdata[w]);
                check("wait_swe", s_we, rq_we[w]);
                check("wait_mdv", m_data_valid, '0);
                // Wiggle the granted master's request to prove it was captured at grant.
                m_addr[w*AW +: AW]  = $urandom;
                m_wdata[w*DW +: DW] = $urandom;
                m_we[w]             = 1'($urandom);
                s_rdata = {$urandom, $urandom, $urandom};
                if (fixed) s_rdata[sel*DW +: DW] = rdv;
                s_data_valid = '0;
                if (stray) s_data_valid[si] = 1'b1;
                if (c == delay) begin
                    s_data_valid[sel] = 1'b1;
                    exp_rd  = rq_we[w] ? 32'h0 : s_rdata[sel*DW +: DW];
                    exp_err = 1'b0;
                    done    = 1'b1;
                end else if (c == TO - 1) begin
                    exp_rd  = 32'h0;
                    exp_err = 1'b1;
                    done    = 1'b1;
                end
                tick();
                c++;
            end
            s_data_valid = '0;
            check("resp_mdv", m_data_valid, exp_mdv);
            check("resp_rdata", m_rdata, exp_rd);
            check("resp_err", m_err, exp_err);
            check("resp_srv", s_req_valid, '0);
        end
        tick();
        rq_v[w] = 1'b0;
        drive_masters();
        check("idle_mdv", m_data_valid, '0);
        check("idle_busy", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b0;
        rq_v         = '0;
        for (int i = 0; i < NM; i++) begin
            rq_addr[i] = '0; rq_wdata[i] = '0; rq_we[i] = 1'b0;
        end
        drive_masters();
        s_data_valid = '0;
        s_rdata      = '0;
        tick();
        tick();
        check("rst_mdv", m_data_valid, '0);
        check("rst_rdata", m_rdata, '0);
        check("rst_err", m_err, 1'b0);
        check("rst_srv", s_req_valid, '0);
        check("rst_saddr", s_addr, '0);
        check("rst_swdata", s_wdata, '0);
        check("rst_swe", s_we, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b1;
        tick();
        tick();

        // Single read: master 0, slave 0 answers in the second WAIT cycle.
        rq_v = 2'b01; rq_addr[0] = 32'h0000_0010; rq_we[0] = 1'b0; rq_wdata[0] = 32'h0;
        run_txn(1, 1'b0, 1'b1, 32'hDEAD_BEEF);

        // Arbitration: both masters hammer slave 1 with single-cycle responses.
        for (int n = 0; n < 4; n++) begin
            rq_v = 2'b11;
            rq_addr[0] = 32'h4000_0000; rq_addr[1] = 32'h4000_0000;
            rq_we[0] = 1'b0; rq_we[1] = 1'b0;
            run_txn(0, 1'b0, 1'b0, 32'h0);
        end

        // Decode error from master 1.
        rq_v = 2'b10; rq_addr[1] = 32'hC000_0000; rq_we[1] = 1'b0;
        run_txn(0, 1'b0, 1'b0, 32'h0);

        // Timeout on slave 2, then a fresh request is accepted.
        rq_v = 2'b01; rq_addr[0] = 32'h8000_0020; rq_we[0] = 1'b0;
        run_txn(-1, 1'b0, 1'b0, 32'h0);
        rq_v = 2'b01; rq_addr[0] = 32'h0000_0040; rq_we[0] = 1'b0;
        run_txn(0, 1'b0, 1'b1, 32'hA5A5_0001);

        // Write to slave 2 with stray strobes from slave 0.
        rq_v = 2'b10; rq_addr[1] = 32'h8000_0100; rq_we[1] = 1'b1; rq_wdata[1] = 32'h1234_5678;
        run_txn(3, 1'b1, 1'b0, 32'h0);

        // Completion in the timeout's final cycle is a completion.
        rq_v = 2'b01; rq_addr[0] = 32'h4000_0008; rq_we[0] = 1'b0;
        run_txn(TO - 1, 1'b0, 1'b1, 32'h0BAD_F00D);

        // Randomized traffic; pending requests are held until served.
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < NM; i++) begin
                if (!rq_v[i] && ($urandom_range(0, 1) == 1)) begin
                    rq_v[i]     = 1'b1;
                    rq_addr[i]  = {2'($urandom_range(0, 3)), 30'($urandom)};
                    rq_wdata[i] = $urandom;
                    rq_we[i]    = 1'($urandom);
                end
            end
            if (rq_v == '0) begin
                rq_v[0]     = 1'b1;
                rq_addr[0]  = {2'($urandom_range(0, 2)), 30'($urandom)};
                rq_wdata[0] = $urandom;
                rq_we[0]    = 1'($urandom);
            end
            run_txn($urandom_range(0, 10), 1'($urandom), 1'b0, 32'h0);
        end

        // Reset in the middle of WAIT.
        rq_v = 2'b10; rq_addr[1] = 32'h4000_0004; rq_we[1] = 1'b0;
        if (rq_v[0]) rq_v[0] = 1'b0;
        drive_masters();
        tick();
        check("rstwait_pre_srv", s_req_valid, 3'b010);
        tick();
        #2;
        reset = 1'b0;
        #1;
        check("rstwait_srv", s_req_valid, '0);
        check("rstwait_busy", busy, 1'b0);
        check("rstwait_mdv", m_data_valid, '0);
        check("rstwait_saddr", s_addr, '0);
        rq_v = '0;
        drive_masters();
        tick();
        check("rstwait_hold_mdv", m_data_valid, '0);
        reset      = 1'b1;
        model_last = NM - 1;
        tick();
        check("rstwait_after_mdv", m_data_valid, '0);
        rq_v = 2'b11; rq_addr[0] = 32'h0000_0004; rq_addr[1] = 32'h0000_0008;
        rq_we[0] = 1'b0; rq_we[1] = 1'b0;
        run_txn(0, 1'b0, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
